// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port among dcache0/1 and icache0/1.
// Ports: CLK/RST, per-requester req_* lines, ram* controller port, gnt_* debug.

package ram_arb_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

endpackage

module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MAXWAIT = 8,
    parameter int CNTW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       req_ren,
    input  logic [3:0]       req_wen,
    input  logic [3:0][31:0] req_addr,
    input  logic [3:0][31:0] req_store,
    output logic [3:0]       req_wait,
    output logic [3:0][31:0] req_load,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  ramstate_t        ramstate,
    output logic             gnt_valid,
    output logic [1:0]       gnt_id
);

    localparam logic [CNTW-1:0] AGE_MAX = CNTW'(MAXWAIT);

    arb_state_t      state;
    arb_state_t      state_n;
    logic [1:0]      owner;
    logic [1:0]      win;
    logic            dlast;
    logic            ilast;
    logic [CNTW-1:0] age2;
    logic [CNTW-1:0] age3;
    logic [CNTW-1:0] age2_n;
    logic [CNTW-1:0] age3_n;
    logic [3:0]      act;
    logic            aged2;
    logic            aged3;
    logic            grant;
    logic            in_xfer;
    logic            srv2;
    logic            srv3;

    assign act     = req_ren | req_wen;
    assign in_xfer = (state == ARB_XFER);
    assign grant   = (state == ARB_IDLE) && (|act);

    // A stale saturated count must not promote a requester that went away.
    assign aged2 = act[2] && (age2 == AGE_MAX);
    assign aged3 = act[3] && (age3 == AGE_MAX);

    // Winner: aged instruction > data > instruction.
    // Within a class the index other than the last grant wins a tie.
    always_comb begin
        win = 2'd0;
        if (aged2 && aged3) begin
            win = {1'b1, ~ilast};
        end else if (aged2) begin
            win = 2'd2;
        end else if (aged3) begin
            win = 2'd3;
        end else if (act[0] && act[1]) begin
            win = {1'b0, ~dlast};
        end else if (act[0]) begin
            win = 2'd0;
        end else if (act[1]) begin
            win = 2'd1;
        end else if (act[2] && act[3]) begin
            win = {1'b1, ~ilast};
        end else if (act[2]) begin
            win = 2'd2;
        end else if (act[3]) begin
            win = 2'd3;
        end
    end

    // Served = granted this cycle or currently owning the port.
    assign srv2 = (grant && (win == 2'd2)) || (in_xfer && (owner == 2'd2));
    assign srv3 = (grant && (win == 2'd3)) || (in_xfer && (owner == 2'd3));

    always_comb begin
        age2_n = age2;
        if (!act[2] || srv2) begin
            age2_n = '0;
        end else if (age2 != AGE_MAX) begin
            age2_n = age2 + CNTW'(1);
        end
    end

    always_comb begin
        age3_n = age3;
        if (!act[3] || srv3) begin
            age3_n = '0;
        end else if (age3 != AGE_MAX) begin
            age3_n = age3 + CNTW'(1);
        end
    end

    // Transfer ends on completion, on error (requester retries later),
    // or when the owner withdraws its request.
    always_comb begin
        state_n = state;
        unique case (state)
            ARB_IDLE: begin
                if (grant) begin
                    state_n = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (ramstate == ACCESS || ramstate == ERROR || !act[owner]) begin
                    state_n = ARB_IDLE;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ARB_IDLE;
            owner <= 2'd0;
            dlast <= 1'b1;
            ilast <= 1'b1;
            age2  <= '0;
            age3  <= '0;
        end else begin
            state <= state_n;
            age2  <= age2_n;
            age3  <= age3_n;
            if (grant) begin
                owner <= win;
                if (win[1]) begin
                    ilast <= win[0];
                end else begin
                    dlast <= win[0];
                end
            end
        end
    end

    // Port outputs follow the registered owner; write beats read.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        req_wait = 4'b1111;
        req_load = '0;
        if (in_xfer) begin
            ramaddr  = req_addr[owner];
            ramstore = req_store[owner];
            if (req_wen[owner]) begin
                ramWEN = 1'b1;
            end else begin
                ramREN = req_ren[owner];
            end
            req_wait[owner] = (ramstate != ACCESS);
            req_load[owner] = ramload;
        end
    end

    assign gnt_valid = in_xfer;
    assign gnt_id    = owner;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vector table plus a hand-written
// multi-cycle wait sequence for ram_port_arbiter (MAXWAIT = 3).

module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam logic [31:0] LOAD = 32'hCAFE_F00D;
    localparam logic [31:0] ADDR [4] = '{32'h100, 32'h200, 32'h40, 32'h300};
    localparam logic [31:0] STOR [4] = '{32'h5000_0000, 32'h5000_0001,
                                        32'h5000_0002, 32'h5000_0003};

    logic             CLK;
    logic             RST;
    logic [3:0]       req_ren;
    logic [3:0]       req_wen;
    logic [3:0][31:0] req_addr;
    logic [3:0][31:0] req_store;
    logic [3:0]       req_wait;
    logic [3:0][31:0] req_load;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    ramstate_t        ramstate;
    logic             gnt_valid;
    logic [1:0]       gnt_id;

    ram_port_arbiter #(.MAXWAIT(3), .CNTW(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wait  (req_wait),
        .req_load  (req_load),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        bit         rst;
        bit [3:0]   ren;
        bit [3:0]   wen;
        ramstate_t  rs;
        bit         ev;
        bit [1:0]   eid;
        bit         er;
        bit         ew;
        bit [3:0]   ewait;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(string n, bit r, bit [3:0] ren, bit [3:0] wen,
                       ramstate_t rs, bit ev, bit [1:0] id,
                       bit er, bit ew, bit [3:0] wt);
        vec_t v;
        v.name = n; v.rst = r; v.ren = ren; v.wen = wen; v.rs = rs;
        v.ev = ev; v.eid = id; v.er = er; v.ew = ew; v.ewait = wt;
        vecs.push_back(v);
    endtask

    task automatic chk(string n, string f, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h required %h", n, f, got, exp);
        end
    endtask

    task automatic check_vec(vec_t v);
        logic [31:0] ea;
        logic [31:0] es;
        logic [3:0][31:0] el;
        ea = v.ev ? ADDR[v.eid] : 32'h0;
        es = v.ev ? STOR[v.eid] : 32'h0;
        el = '0;
        if (v.ev) el[v.eid] = LOAD;
        chk(v.name, "gnt_valid", 32'(gnt_valid), 32'(v.ev));
        chk(v.name, "gnt_id", 32'(gnt_id), 32'(v.eid));
        chk(v.name, "ramREN", 32'(ramREN), 32'(v.er));
        chk(v.name, "ramWEN", 32'(ramWEN), 32'(v.ew));
        chk(v.name, "ramaddr", ramaddr, ea);
        chk(v.name, "ramstore", ramstore, es);
        chk(v.name, "req_wait", 32'(req_wait), 32'(v.ewait));
        for (int j = 0; j < 4; j++) begin
            chk(v.name, $sformatf("req_load%0d", j), req_load[j], el[j]);
        end
    endtask

    initial begin
        // reset state
        add("rst_idle", 0, 4'b0000, 4'b0000, FREE,   0, 0, 0, 0, 4'b1111);
        // single icache0 read, ACCESS on 2nd XFER cycle
        add("ic0_a1",   0, 4'b0100, 4'b0000, FREE,   0, 0, 0, 0, 4'b1111);
        add("ic0_a2",   0, 4'b0100, 4'b0000, BUSY,   1, 2, 1, 0, 4'b1111);
        add("ic0_a3",   0, 4'b0100, 4'b0000, ACCESS, 1, 2, 1, 0, 4'b1011);
        add("ic0_a4",   0, 4'b0000, 4'b0000, FREE,   0, 2, 0, 0, 4'b1111);
        // class priority from reset: 1, 2, 3
        add("cls_rst",  1, 4'b1110, 4'b0000, ACCESS, 0, 2, 0, 0, 4'b1111);
        add("cls_b1",   0, 4'b1110, 4'b0000, ACCESS, 0, 0, 0, 0, 4'b1111);
        add("cls_b2",   0, 4'b1110, 4'b0000, ACCESS, 1, 1, 1, 0, 4'b1101);
        add("cls_b3",   0, 4'b1100, 4'b0000, ACCESS, 0, 1, 0, 0, 4'b1111);
        add("cls_b4",   0, 4'b1100, 4'b0000, ACCESS, 1, 2, 1, 0, 4'b1011);
        add("cls_b5",   0, 4'b1000, 4'b0000, ACCESS, 0, 2, 0, 0, 4'b1111);
        add("cls_b6",   0, 4'b1000, 4'b0000, ACCESS, 1, 3, 1, 0, 4'b0111);
        add("cls_b7",   0, 4'b0000, 4'b0000, ACCESS, 0, 3, 0, 0, 4'b1111);
        // data round-robin writes: 0,1,0,1
        add("rr_c1",    0, 4'b0000, 4'b0011, ACCESS, 0, 3, 0, 0, 4'b1111);
        add("rr_c2",    0, 4'b0000, 4'b0011, ACCESS, 1, 0, 0, 1, 4'b1110);
        add("rr_c3",    0, 4'b0000, 4'b0011, ACCESS, 0, 0, 0, 0, 4'b1111);
        add("rr_c4",    0, 4'b0000, 4'b0011, ACCESS, 1, 1, 0, 1, 4'b1101);
        add("rr_c5",    0, 4'b0000, 4'b0011, ACCESS, 0, 1, 0, 0, 4'b1111);
        add("rr_c6",    0, 4'b0000, 4'b0011, ACCESS, 1, 0, 0, 1, 4'b1110);
        add("rr_c7",    0, 4'b0000, 4'b0011, ACCESS, 0, 0, 0, 0, 4'b1111);
        add("rr_c8",    0, 4'b0000, 4'b0011, ACCESS, 1, 1, 0, 1, 4'b1101);
        add("rr_c9",    0, 4'b0000, 4'b0000, ACCESS, 0, 1, 0, 0, 4'b1111);
        // aging: icache1 promoted ahead of pending data
        add("age_d1",   0, 4'b1000, 4'b0011, ACCESS, 0, 1, 0, 0, 4'b1111);
        add("age_d2",   0, 4'b1000, 4'b0011, ACCESS, 1, 0, 0, 1, 4'b1110);
        add("age_d3",   0, 4'b1000, 4'b0011, ACCESS, 0, 0, 0, 0, 4'b1111);
        add("age_d4",   0, 4'b1000, 4'b0011, ACCESS, 1, 1, 0, 1, 4'b1101);
        add("age_d5",   0, 4'b1000, 4'b0011, ACCESS, 0, 1, 0, 0, 4'b1111);
        add("age_d6",   0, 4'b1000, 4'b0011, ACCESS, 1, 3, 1, 0, 4'b0111);
        add("age_d7",   0, 4'b1000, 4'b0011, ACCESS, 0, 3, 0, 0, 4'b1111);
        add("age_d8",   0, 4'b1000, 4'b0011, ACCESS, 1, 0, 0, 1, 4'b1110);
        add("age_d9",   0, 4'b0000, 4'b0000, ACCESS, 0, 0, 0, 0, 4'b1111);
        // abort: dcache0 drops wen mid-XFER
        add("abt_e1",   0, 4'b0000, 4'b0001, FREE,   0, 0, 0, 0, 4'b1111);
        add("abt_e2",   0, 4'b0000, 4'b0001, BUSY,   1, 0, 0, 1, 4'b1111);
        add("abt_e3",   0, 4'b0000, 4'b0000, BUSY,   1, 0, 0, 0, 4'b1111);
        add("abt_e4",   0, 4'b0000, 4'b0000, FREE,   0, 0, 0, 0, 4'b1111);
        // error: wait held, back to idle, re-grant
        add("err_e5",   0, 4'b0010, 4'b0000, FREE,   0, 0, 0, 0, 4'b1111);
        add("err_e6",   0, 4'b0010, 4'b0000, ERROR,  1, 1, 1, 0, 4'b1111);
        add("err_e7",   0, 4'b0010, 4'b0000, FREE,   0, 1, 0, 0, 4'b1111);
        add("err_e8",   0, 4'b0010, 4'b0000, ACCESS, 1, 1, 1, 0, 4'b1101);
        add("err_e9",   0, 4'b0000, 4'b0000, FREE,   0, 1, 0, 0, 4'b1111);
        // reset during a dcache1 write
        add("mrst_f1",  0, 4'b0000, 4'b0010, BUSY,   0, 1, 0, 0, 4'b1111);
        add("mrst_f2",  0, 4'b0000, 4'b0010, BUSY,   1, 1, 0, 1, 4'b1111);
        add("mrst_f3",  1, 4'b0000, 4'b0010, BUSY,   1, 1, 0, 1, 4'b1111);
        add("mrst_f4",  0, 4'b1100, 4'b0011, BUSY,   0, 0, 0, 0, 4'b1111);
        add("mrst_f5",  0, 4'b1100, 4'b0011, BUSY,   1, 0, 0, 1, 4'b1111);
        add("mrst_f6",  0, 4'b0000, 4'b0000, BUSY,   1, 0, 0, 0, 4'b1111);
        add("mrst_f7",  0, 4'b0000, 4'b0000, FREE,   0, 0, 0, 0, 4'b1111);

        for (int i = 0; i < 4; i++) begin
            req_addr[i]  = ADDR[i];
            req_store[i] = STOR[i];
        end
        ramload  = LOAD;
        RST      = 1'b1;
        req_ren  = '0;
        req_wen  = '0;
        ramstate = FREE;
        repeat (2) @(negedge CLK);

        foreach (vecs[i]) begin
            if (i != 0) @(negedge CLK);
            RST      = vecs[i].rst;
            req_ren  = vecs[i].ren;
            req_wen  = vecs[i].wen;
            ramstate = vecs[i].rs;
            #1;
            check_vec(vecs[i]);
        end

        // icache1 read held BUSY for three transfer cycles, bounded wait
        begin
            int  k;
            bit  seen;
            seen = 1'b0;
            k = 0;
            while (!seen && k < 12) begin
                @(negedge CLK);
                RST      = 1'b0;
                req_ren  = 4'b1000;
                req_wen  = 4'b0000;
                ramstate = (k >= 4) ? ACCESS : BUSY;
                #1;
                if (req_wait[3] == 1'b0) begin
                    seen = 1'b1;
                    chk("slow_ic1", "cycle", 32'(k), 32'd4);
                    chk("slow_ic1", "load", req_load[3], LOAD);
                    chk("slow_ic1", "ramREN", 32'(ramREN), 32'd1);
                    chk("slow_ic1", "ramaddr", ramaddr, ADDR[3]);
                end else begin
                    k++;
                end
            end
            if (!seen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL slow_ic1.timeout: got no completion required req_wait[3]=0");
            end
            @(negedge CLK);
            req_ren  = 4'b0000;
            ramstate = FREE;
            #1;
            chk("slow_ic1", "idle_after", 32'(gnt_valid), 32'd0);
            chk("slow_ic1", "wait_after", 32'(req_wait), 32'hF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single RAM port among the four cache requesters of the dual-core system: dcache0, dcache1, icache0 and icache1. It sits between the cache request/response lines and the memory controller's `ramREN`/`ramWEN`/`ramaddr`/`ramstore`/`ramload`/`ramstate` port. Data requesters win over instruction requesters, and round-robin applies within each class. An aging counter promotes a starved instruction requester above data traffic.

## Interface
- `MAXWAIT`, default 8: cycles an instruction request may wait while unserved before it is promoted; must be ≥1.
- `CNTW`, default 4: width of each aging counter; must satisfy `MAXWAIT < 2**CNTW`.

Ports (requester index: 0 = dcache0, 1 = dcache1, 2 = icache0, 3 = icache1):
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `req_ren` in 4: read request per requester.
- `req_wen` in 4: write request per requester.
- `req_addr` in 4×32: word address per requester.
- `req_store` in 4×32: write data per requester.
- `req_wait` out 4: 0 means the requester's access completes this cycle.
- `req_load` out 4×32: read data; valid only when the matching `req_wait` is 0.
- `ramREN`, `ramWEN` out 1: RAM strobes.
- `ramaddr`, `ramstore` out 32: RAM address and write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: `ramstate_t` (FREE, BUSY, ACCESS, ERROR).
- `gnt_valid` out 1, `gnt_id` out 2: current owner, for debug and coherence snooping.

## Operation
- A requester is active when `req_ren[i] | req_wen[i]`.
- **State machine:** `ARB_IDLE` and `ARB_XFER`. `RST` forces `ARB_IDLE`.
- **ARB_IDLE**
  - RAM strobes are 0; all `req_wait` are 1.
  - If any requester is active, the winner is latched into `owner`, the pointers update, and the next state is `ARB_XFER`.
- **Winner selection**, in strict priority order:
  1. Aged instruction requester (aging count == `MAXWAIT`). If both are aged, round-robin via `ilast`.
  2. Active data requester. If both are active, the one ≠ `dlast` wins.
  3. Active instruction requester. If both are active, the one ≠ `ilast` wins.
- **Pointer update:** `dlast` or `ilast` takes the granted index within its class. Reset values are `dlast = 1` and `ilast = 1`, so index 0 of each class wins the first tie.
- **ARB_XFER**, driving from `owner`:
  - `ramaddr = req_addr[owner]` and `ramstore = req_store[owner]`.
  - If `req_wen[owner]` is 1, then `ramWEN = 1` and `ramREN = 0`; write wins when both are asserted.
  - Otherwise `ramREN = req_ren[owner]`.
  - `req_wait[owner] = (ramstate != ACCESS)`; all other `req_wait` are 1.
  - `req_load[owner] = ramload`; all other `req_load` are 0.
- **Leaving ARB_XFER:**
  - `ramstate == ACCESS` → `ARB_IDLE`.
  - `ramstate == ERROR` → `ARB_IDLE` with `req_wait[owner]` held at 1, so the requester retries.
  - Owner drops both `ren` and `wen` (abort) → `ARB_IDLE` with RAM strobes 0 in that same cycle.
- **Aging counters** (one each for indices 2 and 3, saturating at `MAXWAIT`):
  - Increment each cycle the requester is active and is not being served, in either state.
  - Clear when the requester is granted or when it is inactive.
- **Outputs:** `gnt_valid = (state == ARB_XFER)`; `gnt_id = owner`.
- **Reset values:**
  - Outputs: `ramREN = 0`, `ramWEN = 0`, `ramaddr = 0`, `ramstore = 0`, `req_wait = 4'b1111`, `req_load` all 0, `gnt_valid = 0`, `gnt_id = 0`.
  - Internal: `owner = 0`, counters 0.

## Timing
- Request active in `ARB_IDLE` at cycle N → owner registered at edge N+1; RAM strobes are driven from cycle N+1.
- `ramstate == ACCESS` at cycle M → `req_wait[owner] = 0` and `req_load` are valid in cycle M; `ARB_IDLE` at M+1.
- Minimum occupancy is 2 cycles per access (one arbitration cycle plus one transfer cycle).
- Back-to-back accesses from the same requester are re-arbitrated each time; there is no grant hold.
- A requester must deassert, or present its next address, in the cycle after it sees `req_wait = 0`. If it is still active in `ARB_IDLE`, that counts as a new request.
- `RST` asserted in `ARB_XFER` → RAM strobes are 0 at the next edge; a partial write is the RAM's concern.
- Owner outputs are combinational from `owner` and `ramstate`; `owner` and state are registered.

## Test plan
- **Single icache0 read:** `req_ren = 4'b0100`, `addr = 0x40`, RAM gives ACCESS on the 2nd XFER cycle. Required: `ramREN = 1`, `ramaddr = 0x40`; `req_wait[2] = 0` with `req_load[2] = ramload` exactly one cycle; back to `ARB_IDLE`.
- **Class priority:** icache0, dcache1 and icache1 all active at reset. Required grant order: 1, 2, 3 (data first, then icache0 by tie rule).
- **Data round-robin:** dcache0 and dcache1 continuously writing, ACCESS immediate. Required: grants alternate 0,1,0,1; `ramWEN = 1` each XFER; `ramstore` matches the owner.
- **Aging with `MAXWAIT = 3`:** dcache0 and dcache1 saturate the port while icache1 holds a read. Required: icache1 is granted at the first `ARB_IDLE` after its counter reaches 3, ahead of pending data.
- **Abort and error:** owner dcache0 drops `wen` mid-XFER → `ramWEN = 0` the same cycle, then `ARB_IDLE`. `ramstate = ERROR` → `req_wait[owner]` stays 1, then `ARB_IDLE`, then re-grant.
- **Reset mid-XFER:** `RST` high for one cycle during a write. Required: all outputs at reset values next cycle; first grant after reset follows the tie rules.
